audio_i2s_tx: RTL and testbench

- Audio sink for the tone generator. Produces the sample-rate strobe `ena` that the generator uses to advance its NCO.
- Captures the generator's stereo 24-bit samples (`l_data`, `r_data`) once per frame.
- Serializes them in I2S format (BCLK / LRCK / SDATA) to the board audio DAC/codec.
- Sits between the generator and the codec pins; it is the only timing master of the audio path.

---
 rtl/audio_i2s_tx.sv | 118 +++++++++++
 tb/tb_audio_i2s_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter and sample-rate master for the tone generator.
// A free-running clock divider produces BCLK. A bit counter walks each
// 2*SLOT_BITS-bit frame and drives LRCK. A one-clk `ena` strobe at the start
// of each frame asks the generator for a new stereo sample. The sample is
// captured one clk later and serialised MSB first with the standard I2S
// one-BCLK delay.
module audio_i2s_tx #(
    parameter int BCLK_HALF = 9,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] l_data,
    input  logic [23:0] r_data,
    input  logic        mute,
    output logic        ena,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int PAD_BITS   = SLOT_BITS - 24;
    localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_bclk;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_lrck;
    logic                  r_ena;
    logic [23:0]           r_l_hold;
    logic [23:0]           r_r_hold;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_sdata;

    logic                  w_div_tc;
    logic                  w_fall;
    logic [BIT_W-1:0]      w_bit_next;
    logic [FRAME_BITS-1:0] w_frame;

    // The divider has reached its terminal count, so BCLK toggles this cycle.
    assign w_div_tc   = (r_div_cnt == DIV_LAST);
    // BCLK is currently high and is about to fall. All data changes happen here.
    assign w_fall     = w_div_tc & r_bclk;
    assign w_bit_next = (r_bit == BIT_LAST) ? '0 : (r_bit + BIT_ONE);
    // Frame image: each slot carries 24 sample bits, MSB first, then zero padding.
    assign w_frame    = {r_l_hold, {PAD_BITS{1'b0}}, r_r_hold, {PAD_BITS{1'b0}}};

    // BCLK divider: BCLK toggles every BCLK_HALF clk cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Bit position, word select and frame-start strobe advance on falling BCLK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit  <= BIT_LAST;
            r_lrck <= 1'b1;
            r_ena  <= 1'b0;
        end else begin
            r_ena <= w_fall && (w_bit_next == '0);
            if (w_fall) begin
                r_bit  <= w_bit_next;
                r_lrck <= (w_bit_next >= BIT_SLOT);
            end
        end
    end

    // Capture the generator's sample (or silence) one clk after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l_hold <= '0;
            r_r_hold <= '0;
        end else if (r_ena) begin
            r_l_hold <= mute ? 24'd0 : l_data;
            r_r_hold <= mute ? 24'd0 : r_data;
        end
    end

    // Serialiser. At b=1 the frame image loads and its MSB goes straight out,
    // so the register keeps only the bits that are still to be sent. On every
    // other falling edge the next stored bit is shifted out. At b=0 that bit is
    // the final pad zero of the frame that is ending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_sdata <= 1'b0;
        end else if (w_fall) begin
            if (w_bit_next == BIT_ONE) begin
                r_sdata <= w_frame[FRAME_BITS-1];
                r_shift <= {w_frame[FRAME_BITS-2:0], 1'b0};
            end else begin
                r_sdata <= r_shift[FRAME_BITS-1];
                r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign ena   = r_ena;
    assign bclk  = r_bclk;
    assign lrck  = r_lrck;
    assign sdata = r_sdata;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: randomized scoreboard bench for the I2S transmitter.
// The driver acts as the generator. It presents a new sample on the strobe
// cycle and pushes the expected frame. Later in the frame it drives glitch
// values. An independent monitor decodes BCLK/LRCK/SDATA like a codec would
// and checks frame content and all timing relationships.
module tb_audio_i2s_tx;

    localparam int BCLK_HALF  = 9;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_CLKS = 2 * BCLK_HALF * 2 * SLOT_BITS;
    localparam int NF1        = 10;
    localparam int NF2        = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] l_data;
    logic [23:0] r_data;
    logic        mute;
    logic        ena;
    logic        bclk;
    logic        lrck;
    logic        sdata;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_q[$];

    audio_i2s_tx #(
        .BCLK_HALF(BCLK_HALF),
        .SLOT_BITS(SLOT_BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .l_data(l_data),
        .r_data(r_data),
        .mute  (mute),
        .ena   (ena),
        .bclk  (bclk),
        .lrck  (lrck),
        .sdata (sdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // clk cycles since reset release; 1 at the first edge after release
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- monitor ----------------
    logic        prev_bclk, prev_lrck, prev_ena;
    bit          seen_bclk, seen_lrck, seen_ena;
    int          last_bclk_cyc, last_ena_cyc, lrck_run, nbits;
    logic [63:0] sd_frame, lr_frame;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_bclk = 1'b0; prev_lrck = 1'b1; prev_ena = 1'b0;
            seen_bclk = 0; seen_lrck = 0; seen_ena = 0;
            lrck_run = 0; nbits = -1;
        end else begin
            if (bclk != prev_bclk) begin
                if (!seen_bclk) begin
                    check("first_bclk_rise_cyc", 64'(cyc), 64'(BCLK_HALF));
                    check("first_bclk_is_rise", 64'(bclk), 64'd1);
                end else begin
                    check("bclk_half_period", 64'(cyc - last_bclk_cyc), 64'(BCLK_HALF));
                end
                seen_bclk = 1;
                last_bclk_cyc = cyc;
                if (!bclk) lrck_run++;
                if (bclk && nbits >= 0) begin
                    sd_frame = {sd_frame[62:0], sdata};
                    lr_frame = {lr_frame[62:0], lrck};
                    nbits++;
                    if (nbits == 2 * SLOT_BITS) begin
                        nbits = -1;
                        if (exp_q.size() == 0) begin
                            check("frame_has_expected", 64'd0, 64'd1);
                        end else begin
                            logic [47:0] e;
                            logic [63:0] want;
                            e = exp_q.pop_front();
                            // each slot: one delay bit, 24 data bits, pad zeros
                            want = ({40'd0, e[47:24]} << (2 * SLOT_BITS - 1 - 24))
                                 | ({40'd0, e[23:0]}  << (SLOT_BITS - 1 - 24));
                            check("frame_sdata", sd_frame, want);
                            check("frame_lrck", lr_frame, {32'h0, 32'hFFFF_FFFF});
                        end
                    end
                end
            end
            if (lrck != prev_lrck) begin
                if (!seen_lrck) check("first_lrck_fall_cyc", 64'(cyc), 64'(2 * BCLK_HALF));
                else            check("lrck_run_bclks", 64'(lrck_run), 64'(SLOT_BITS));
                seen_lrck = 1;
                lrck_run = 0;
            end
            if (ena) begin
                check("ena_single_cycle", 64'(prev_ena), 64'd0);
                check("lrck_low_at_ena", 64'(lrck), 64'd0);
                check("no_ena_mid_frame", 64'(nbits >= 0), 64'd0);
                if (!seen_ena) check("first_ena_cyc", 64'(cyc), 64'(2 * BCLK_HALF));
                else           check("ena_period", 64'(cyc - last_ena_cyc), 64'(FRAME_CLKS));
                seen_ena = 1;
                last_ena_cyc = cyc;
                nbits = 0;
            end
            prev_bclk = bclk; prev_lrck = lrck; prev_ena = ena;
        end
    end

    // ---------------- driver ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_ena"},   64'(ena),   64'd0);
        check({tag, "_bclk"},  64'(bclk),  64'd0);
        check({tag, "_lrck"},  64'(lrck),  64'd1);
        check({tag, "_sdata"}, 64'(sdata), 64'd0);
    endtask

    task automatic wait_ena(output bit ok);
        ok = 0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (ena) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("ena_timeout", 64'd0, 64'd1);
    endtask

    // Generator behaviour: new sample appears on the strobe cycle.
    task automatic present_sample(input int f);
        logic [23:0] l, r;
        logic        m;
        case (f)
            0, 1:    begin l = 24'hA5F00F; r = 24'h123456; m = 1'b0; end
            2:       begin l = 24'h800000; r = 24'h7FFFFF; m = 1'b0; end
            3:       begin l = 24'h800000; r = 24'h7FFFFF; m = 1'b1; end
            default: begin l = 24'($urandom); r = 24'($urandom); m = ($urandom_range(0, 3) == 0); end
        endcase
        l_data = l;
        r_data = r;
        mute   = m;
        exp_q.push_back(m ? 48'd0 : {l, r});
    endtask

    task automatic glitch_mid_frame();
        @(posedge clk);
        repeat ($urandom_range(2, 1000)) @(negedge clk);
        l_data = 24'($urandom);
        r_data = 24'($urandom);
        mute   = 1'($urandom);
    endtask

    initial begin
        bit ok;
        int f;
        rst_n  = 1'b0;
        l_data = '0;
        r_data = '0;
        mute   = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("startup_reset");
        rst_n = 1'b1;

        f = 0;
        for (int k = 0; k < NF1; k++) begin
            wait_ena(ok);
            present_sample(f);
            f++;
            if (k >= 4) glitch_mid_frame();
        end

        // Reset in the left slot at b=10: this frame is abandoned.
        wait_ena(ok);
        present_sample(f);
        f++;
        begin
            int   falls;
            logic pb;
            falls = 0;
            pb = bclk;
            for (int i = 0; i < 40 * BCLK_HALF && falls < 10; i++) begin
                @(negedge clk);
                if (pb && !bclk) falls++;
                pb = bclk;
            end
            check("falls_before_reset", 64'(falls), 64'd10);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < NF2; k++) begin
            wait_ena(ok);
            present_sample(f + 10);
            f++;
            glitch_mid_frame();
        end

        // One more strobe means every pushed frame has been fully received.
        wait_ena(ok);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
